// File: rtl/spwm_pkg.sv
// rtl/spwm_pkg.sv - shared encodings for the SPWM carrier generator
package spwm_pkg;

    typedef enum logic [1:0] {
        MODE_TRI    = 2'd0,
        MODE_SAW_UP = 2'd1,
        MODE_SAW_DN = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/carrier_fold.sv
// rtl/carrier_fold.sv - combinational fold of a carrier phase into a carrier value
module carrier_fold
    import spwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [CNT_W:0]   p,
    input  logic [CNT_W-1:0] peak,
    input  mode_t            mode,
    output logic [CNT_W-1:0] value
);

    always_comb begin
        value = '0;
        case (mode)
            // descending half of the triangle: 2*peak - p always lands in 1..peak
            MODE_TRI:    value = (p < {1'b0, peak}) ? p[CNT_W-1:0]
                                                    : CNT_W'({peak, 1'b0} - p);
            MODE_SAW_UP: value = p[CNT_W-1:0];
            MODE_SAW_DN: value = peak - p[CNT_W-1:0];
            default:     value = '0;
        endcase
    end

endmodule

// File: rtl/phase_shifted_carrier_gen.sv
// rtl/phase_shifted_carrier_gen.sv - N_CH phase-shifted triangle/sawtooth carrier generator
module phase_shifted_carrier_gen
    import spwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    sync,
    input  logic                    step,
    input  logic [1:0]              mode,
    input  logic [CNT_W-1:0]        peak,
    input  logic [CNT_W:0]          phase_step,
    output logic [N_CH*CNT_W-1:0]   value,
    output logic                    peak_pulse,
    output logic                    valley_pulse,
    output logic                    running,
    output logic                    cfg_err
);

    localparam int PH_W  = CNT_W + 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   sh_peak;
    mode_t              sh_mode;
    logic [PH_W-1:0]    sh_pstep;
    logic [PH_W-1:0]    sh_period;
    logic [PH_W-1:0]    wrap_max;

    logic [PH_W-1:0]    cand_period;
    logic               cfg_ok;
    logic               req_cfg;
    logic               accept;
    logic               reject;

    logic [PH_W-1:0]    acc;
    logic [PH_W:0]      acc_sum;
    logic [PH_W-1:0]    acc_nxt;
    logic [IDX_W-1:0]   init_idx;
    logic               init_last;
    logic               init_load;

    logic               run_step;
    logic               ph_upd;

    logic [PH_W-1:0]    phase    [N_CH];
    logic [CNT_W-1:0]   fold_val [N_CH];

    // candidate configuration is evaluated from the live inputs
    always_comb begin
        cand_period = (mode_t'(mode) == MODE_TRI) ? {peak, 1'b0}
                                                  : ({1'b0, peak} + PH_W'(1));
        cfg_ok      = (peak >= CNT_W'(2)) && (mode_t'(mode) != MODE_RSVD)
                      && (phase_step < cand_period);
        req_cfg     = !stop && ((start && state == IDLE) || (sync && state == RUN));
        accept      = req_cfg && cfg_ok;
        reject      = req_cfg && !cfg_ok;
    end

    always_comb begin
        wrap_max  = sh_period - PH_W'(1);
        acc_sum   = {1'b0, acc} + {1'b0, sh_pstep};
        acc_nxt   = (acc_sum >= {1'b0, sh_period}) ? PH_W'(acc_sum - {1'b0, sh_period})
                                                   : PH_W'(acc_sum);
        init_last = (init_idx == IDX_W'(N_CH - 1));
        init_load = (state == INIT) && !stop;
        run_step  = (state == RUN) && step && !stop && !accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = INIT;
        end else if (state == INIT && init_last) begin
            state_nxt = RUN;
        end
    end

    assign running = (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_peak   <= '0;
            sh_mode   <= MODE_TRI;
            sh_pstep  <= '0;
            sh_period <= '0;
            acc       <= '0;
            init_idx  <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                sh_peak   <= peak;
                sh_mode   <= mode_t'(mode);
                sh_pstep  <= phase_step;
                sh_period <= cand_period;
                acc       <= '0;
                init_idx  <= '0;
            end else if (init_load) begin
                acc      <= acc_nxt;
                init_idx <= init_idx + IDX_W'(1);
            end
        end
    end

    // INIT seeds one channel per cycle; RUN advances all channels together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_CH; k++) begin
                phase[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (init_load && init_idx == IDX_W'(k)) begin
                    phase[k] <= acc;
                end else if (run_step) begin
                    phase[k] <= (phase[k] == wrap_max) ? '0 : phase[k] + PH_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_fold
        carrier_fold #(
            .CNT_W (CNT_W)
        ) u_fold (
            .p     (phase[g]),
            .peak  (sh_peak),
            .mode  (sh_mode),
            .value (fold_val[g])
        );
    end

    // ph_upd marks that the phases moved, so the next value load may raise an edge pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_upd       <= 1'b0;
            value        <= '0;
            peak_pulse   <= 1'b0;
            valley_pulse <= 1'b0;
        end else begin
            ph_upd <= run_step || (init_load && init_last);
            if (state == RUN) begin
                for (int k = 0; k < N_CH; k++) begin
                    value[k*CNT_W +: CNT_W] <= fold_val[k];
                end
                peak_pulse   <= ph_upd && (fold_val[0] == sh_peak);
                valley_pulse <= ph_upd && (fold_val[0] == '0);
            end else begin
                peak_pulse   <= 1'b0;
                valley_pulse <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phase_shifted_carrier_gen.sv
// tb/tb_phase_shifted_carrier_gen.sv - directed self-checking bench for phase_shifted_carrier_gen
module tb_phase_shifted_carrier_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        sync;
    logic        step;
    logic [1:0]  mode;
    logic [7:0]  peak;
    logic [8:0]  phase_step;
    logic [31:0] value;
    logic        peak_pulse;
    logic        valley_pulse;
    logic        running;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    phase_shifted_carrier_gen #(
        .N_CH  (4),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .sync         (sync),
        .step         (step),
        .mode         (mode),
        .peak         (peak),
        .phase_step   (phase_step),
        .value        (value),
        .peak_pulse   (peak_pulse),
        .valley_pulse (valley_pulse),
        .running      (running),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] exp_ch0 [7];
        exp_ch0 = '{8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

        reset = 1'b0; start = 1'b0; stop = 1'b0; sync = 1'b0; step = 1'b0;
        mode = 2'd0; peak = 8'd0; phase_step = 9'd0;
        #3;
        check("reset_value", value, 32'h0);
        check("reset_running", {31'd0, running}, 32'd0);
        check("reset_pulses", {30'd0, peak_pulse, valley_pulse}, 32'd0);
        check("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // TRI peak=4 spacing=2, with step held high through INIT
        mode = 2'd0; peak = 8'd4; phase_step = 9'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        step  = 1'b1;
        tick(); tick(); tick();
        check("tri_init_not_running", {31'd0, running}, 32'd0);
        tick();
        check("tri_init_done_running", {31'd0, running}, 32'd1);
        check("tri_value_held_in_init", value, 32'h0);
        step = 1'b0;
        tick();
        check("tri_first_value", value, 32'h02040200);
        check("tri_first_valley", {30'd0, peak_pulse, valley_pulse}, 32'd1);
        tick();
        check("tri_valley_one_cycle", {30'd0, peak_pulse, valley_pulse}, 32'd0);
        do_step();
        check("tri_step1_value", value, 32'h01030301);
        for (int i = 0; i < 7; i++) begin
            do_step();
            check($sformatf("tri_ch0_step%0d", i + 2), {24'd0, value[7:0]}, {24'd0, exp_ch0[i]});
            check($sformatf("tri_pulses_step%0d", i + 2), {30'd0, peak_pulse, valley_pulse},
                  {30'd0, (i == 2), (i == 6)});
        end
        check("tri_step8_value", value, 32'h02040200);

        // live peak change without sync is ignored
        peak = 8'd6;
        do_step();
        check("peak_change_no_effect", value, 32'h01030301);

        // sync re-latches: TRI peak=6, P=12
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_enters_init", {31'd0, running}, 32'd0);
        tick(); tick(); tick(); tick();
        check("sync_init_done", {31'd0, running}, 32'd1);
        tick();
        check("p12_first_value", value, 32'h06040200);
        check("p12_first_valley", {31'd0, valley_pulse}, 32'd1);
        do_step();
        check("p12_step1", value, 32'h05050301);
        do_step();
        check("p12_step2", value, 32'h04060402);

        // SAW_UP peak=3 spacing=1
        mode = 2'd1; peak = 8'd3; phase_step = 9'd1;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("sawup_value", value, 32'h03020100);
        check("sawup_valley", {30'd0, peak_pulse, valley_pulse}, 32'd1);
        do_step();
        check("sawup_step1", value, 32'h00030201);

        // SAW_DN at the same configuration
        mode = 2'd2;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("sawdn_value", value, 32'h00010203);
        check("sawdn_peak_pulse", {30'd0, peak_pulse, valley_pulse}, 32'd2);
        do_step();
        check("sawdn_step1", value, 32'h03000102);

        // stop beats sync; value holds
        stop = 1'b1; sync = 1'b1;
        tick();
        stop = 1'b0; sync = 1'b0;
        check("stop_sync_idle", {31'd0, running}, 32'd0);
        tick(); tick();
        check("stop_value_held", value, 32'h03000102);

        // rejected configurations
        mode = 2'd0; peak = 8'd1; phase_step = 9'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("peak1_cfg_err", {31'd0, cfg_err}, 32'd1);
        check("peak1_not_running", {31'd0, running}, 32'd0);
        tick();
        check("peak1_cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
        check("peak1_value_held", value, 32'h03000102);
        peak = 8'd4; phase_step = 9'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pstep8_cfg_err", {31'd0, cfg_err}, 32'd1);
        tick();
        check("pstep8_not_running", {31'd0, running}, 32'd0);
        mode = 2'd3; phase_step = 9'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mode3_cfg_err", {31'd0, cfg_err}, 32'd1);

        // sync in IDLE is ignored
        mode = 2'd0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("idle_sync_no_err", {31'd0, cfg_err}, 32'd0);
        tick(); tick(); tick(); tick(); tick();
        check("idle_sync_ignored", {31'd0, running}, 32'd0);

        // async reset mid-RUN
        peak = 8'd4; phase_step = 9'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("rerun_value", value, 32'h02040200);
        do_step();
        check("rerun_step1", value, 32'h01030301);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_value", value, 32'h0);
        check("async_reset_running", {31'd0, running}, 32'd0);
        check("async_reset_pulses", {30'd0, peak_pulse, valley_pulse}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_reset_idle", {31'd0, running}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
